// File: rtl/pulse_emulator_pkg.sv
// rtl/pulse_emulator_pkg.sv - shared widths, defaults and state type for the pulse emulator
package pulse_emulator_pkg;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int PE_FRAC_W        = 8;
  localparam int PE_DECAY_SHIFT   = 4;
  localparam int PE_DEAD_TIME     = 8;
  localparam int PE_PERIOD_W      = 16;

  typedef enum logic [1:0] {PE_IDLE, PE_DEAD, PE_DECAY} pe_state_t;
endpackage

// File: rtl/pe_period_timer.sv
// rtl/pe_period_timer.sv - free-running auto-trigger timer, one tick every period cycles
module pe_period_timer
  import pulse_emulator_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   auto_en,
  input  logic [PE_PERIOD_W-1:0] period,
  output logic                   auto_tick
);
  logic [PE_PERIOD_W-1:0] period_cnt;
  logic [PE_PERIOD_W-1:0] last_cnt;

  // >= rather than == so a period shortened mid-count still ticks at the next compare
  always_comb begin
    last_cnt = (period < PE_PERIOD_W'(2)) ? PE_PERIOD_W'(1) : period - PE_PERIOD_W'(1);
  end

  assign auto_tick = auto_en && (period_cnt >= last_cnt);

  always_ff @(posedge clk) begin
    if (reset || !auto_en || auto_tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PE_PERIOD_W'(1);
    end
  end
endmodule

// File: rtl/pulse_emulator.sv
// rtl/pulse_emulator.sv - step-plus-exponential-decay pulse source with pile-up and dead time
module pulse_emulator
  import pulse_emulator_pkg::*;
#(
  parameter int DATA_W      = SIZE_FILTER_DATA,
  parameter int FRAC_W      = PE_FRAC_W,
  parameter int DECAY_SHIFT = PE_DECAY_SHIFT,
  parameter int DEAD_TIME   = PE_DEAD_TIME,
  parameter int BASELINE    = 0
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [DATA_W-1:0] amplitude,
  input  logic              auto_en,
  input  logic [15:0]       period,
  output logic [DATA_W-1:0] output_data,
  output logic              busy,
  output logic              trig_ack,
  output logic              trig_drop
);
  localparam int ACC_W  = DATA_W + FRAC_W + 1;
  localparam int SUM_W  = DATA_W + 3;
  localparam int DEAD_W = $clog2(DEAD_TIME + 2);
  localparam int PAD_W  = ACC_W + 1 - (DATA_W - 1 + FRAC_W);
  localparam logic signed [SUM_W-1:0] BASE_EXT = SUM_W'(BASELINE);
  localparam logic signed [SUM_W-1:0] OUT_MAX  = SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN  = SUM_W'(-(1 << (DATA_W - 1)));
  localparam logic [DATA_W-1:0]       RESET_OUT = DATA_W'(BASELINE);

  pe_state_t               state;
  logic [ACC_W-1:0]        acc, acc_next, dec;
  logic [ACC_W:0]          acc_sum, add;
  logic [DEAD_W-1:0]       dead_cnt;
  logic [DATA_W-1:0]       amp_reg, amp_sel;
  logic [DATA_W-2:0]       amp_clip;
  logic                    auto_tick, req, accept, drop;
  logic signed [SUM_W-1:0] out_sum;
  logic [DATA_W-1:0]       out_sat;

  pe_period_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .auto_en   (auto_en),
    .period    (period),
    .auto_tick (auto_tick)
  );

  always_comb begin
    amp_sel  = trig ? amplitude : amp_reg;
    amp_clip = amp_sel[DATA_W-1] ? '0 : amp_sel[DATA_W-2:0];
    req      = trig | auto_tick;
    accept   = req && (state != PE_DEAD);
    drop     = req && (state == PE_DEAD);

    // minimum decrement of 1 lets the tail reach exactly zero instead of stalling
    dec = '0;
    if (acc != '0) begin
      dec = acc >> DECAY_SHIFT;
      if (dec == '0) dec = ACC_W'(1);
    end

    add      = accept ? {{PAD_W{1'b0}}, amp_clip, {FRAC_W{1'b0}}} : '0;
    acc_sum  = {1'b0, acc - dec} + add;
    acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    out_sum = BASE_EXT + $signed({2'b00, acc[ACC_W-1:FRAC_W]});
    if (out_sum > OUT_MAX) begin
      out_sat = OUT_MAX[DATA_W-1:0];
    end else if (out_sum < OUT_MIN) begin
      out_sat = OUT_MIN[DATA_W-1:0];
    end else begin
      out_sat = out_sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PE_IDLE;
      acc         <= '0;
      dead_cnt    <= '0;
      amp_reg     <= '0;
      output_data <= RESET_OUT;
      busy        <= 1'b0;
      trig_ack    <= 1'b0;
      trig_drop   <= 1'b0;
    end else begin
      acc         <= acc_next;
      output_data <= out_sat;
      trig_ack    <= accept;
      trig_drop   <= drop;
      if (trig) amp_reg <= amplitude;

      case (state)
        PE_DEAD: begin
          dead_cnt <= dead_cnt - DEAD_W'(1);
          if (dead_cnt == DEAD_W'(1)) state <= PE_DECAY;
        end
        default: begin
          if (accept) begin
            busy <= 1'b1;
            if (DEAD_TIME > 0) begin
              state    <= PE_DEAD;
              dead_cnt <= DEAD_W'(DEAD_TIME);
            end else begin
              state <= PE_DECAY;
            end
          end else if (acc_next == '0) begin
            state <= PE_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= PE_DECAY;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_emulator.sv
// tb/tb_pulse_emulator.sv - self-checking bench: reference model scoreboard plus vector table
module tb_pulse_emulator;
  localparam int     DEAD    = 8;
  localparam int     BASE_B  = -100;
  localparam longint ACC_MAX = (64'd1 << 25) - 1;

  logic        clk = 1'b0;
  logic        reset, trig, auto_en;
  logic [15:0] amplitude, period;
  logic [15:0] out_a, out_b;
  logic        busy_a, ack_a, drop_a, busy_b, ack_b, drop_b;

  always #5 clk = ~clk;

  pulse_emulator #(.DATA_W(16), .FRAC_W(8), .DECAY_SHIFT(4), .DEAD_TIME(DEAD), .BASELINE(0)) dut_a (
    .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude), .auto_en(auto_en),
    .period(period), .output_data(out_a), .busy(busy_a), .trig_ack(ack_a), .trig_drop(drop_a)
  );

  pulse_emulator #(.DATA_W(16), .FRAC_W(8), .DECAY_SHIFT(4), .DEAD_TIME(DEAD), .BASELINE(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude), .auto_en(auto_en),
    .period(period), .output_data(out_b), .busy(busy_b), .trig_ack(ack_b), .trig_drop(drop_b)
  );

  typedef struct {
    int out_a;
    int out_b;
    bit busy;
    bit ack;
    bit drop;
  } exp_t;

  typedef struct {
    int amp;
    bit ack;
    int o0;
    int o1;
    int o2;
  } vec_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  longint m_acc = 0;
  int     m_dead = 0, m_state = 0, m_amp_reg = 0, m_pcnt = 0;

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: evaluated once per rising edge with the inputs that edge samples
  task automatic model_step();
    exp_t   e;
    int     eff, amp;
    bit     tick, req;
    longint dec, nacc;
    if (reset) begin
      m_acc = 0; m_dead = 0; m_state = 0; m_amp_reg = 0; m_pcnt = 0;
      e.out_a = 0; e.out_b = BASE_B; e.busy = 0; e.ack = 0; e.drop = 0;
    end else begin
      eff  = (period < 2) ? 2 : int'(period);
      tick = auto_en && (m_pcnt >= eff - 1);
      m_pcnt = (!auto_en || tick) ? 0 : m_pcnt + 1;
      req  = trig || tick;
      amp  = trig ? int'($signed(amplitude)) : m_amp_reg;
      if (amp < 0) amp = 0;
      if (trig) m_amp_reg = int'($signed(amplitude));
      e.ack   = req && (m_state != 1);
      e.drop  = req && (m_state == 1);
      e.out_a = clamp16(m_acc / 256);
      e.out_b = clamp16(BASE_B + m_acc / 256);
      dec  = (m_acc == 0) ? 0 : ((m_acc / 16 < 1) ? 1 : m_acc / 16);
      nacc = m_acc - dec + (e.ack ? longint'(amp) * 256 : 0);
      if (nacc > ACC_MAX) nacc = ACC_MAX;
      if (e.ack) begin
        m_state = 1; m_dead = DEAD;
      end else if (m_state == 1) begin
        if (m_dead == 1) m_state = 2;
        m_dead--;
      end else begin
        m_state = (nacc == 0) ? 0 : 2;
      end
      m_acc  = nacc;
      e.busy = (m_state != 0);
    end
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    e = sb.pop_front();
    check("sb_out", int'($signed(out_a)), e.out_a);
    check("sb_out_base", int'($signed(out_b)), e.out_b);
    check("sb_busy", int'(busy_a), int'(e.busy));
    check("sb_ack", int'(ack_a), int'(e.ack));
    check("sb_drop", int'(drop_a), int'(e.drop));
    check("sb_b_flags", int'({busy_b, ack_b, drop_b}), int'({e.busy, e.ack, e.drop}));
  endtask

  task automatic wait_idle(input int max_cyc, output bit mono);
    int prev;
    mono = 1'b1;
    prev = int'($signed(out_a));
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (int'($signed(out_a)) > prev) mono = 1'b0;
      prev = int'($signed(out_a));
      if (!busy_a) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: busy=%0d after %0d cycles, required 0", busy_a, max_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   mono;
    int   o5, o6, o11, o12, prev, mino, maxo, t0, n_drop;
    int   acks[$];

    vt[0] = '{amp: 1000,  ack: 1, o0: 1000,  o1: 937,   o2: 878};
    vt[1] = '{amp: -500,  ack: 1, o0: 0,     o1: 0,     o2: 0};
    vt[2] = '{amp: 32767, ack: 1, o0: 32767, o1: 30719, o2: 28799};
    vt[3] = '{amp: 16,    ack: 1, o0: 16,    o1: 15,    o2: 14};
    vt[4] = '{amp: 1,     ack: 1, o0: 1,     o1: 0,     o2: 0};
    vt[5] = '{amp: 0,     ack: 1, o0: 0,     o1: 0,     o2: 0};

    reset = 1'b1; trig = 1'b0; auto_en = 1'b0; amplitude = '0; period = '0;
    repeat (2) cycle();
    check("reset_out", int'($signed(out_a)), 0);
    check("reset_out_base", int'($signed(out_b)), BASE_B);
    reset = 1'b0;

    // idle after reset
    repeat (20) cycle();
    check("idle_out", int'($signed(out_a)), 0);
    check("idle_out_base", int'($signed(out_b)), BASE_B);
    check("idle_busy", int'(busy_a), 0);

    // single pulses from idle
    foreach (vt[i]) begin
      amplitude = 16'(vt[i].amp);
      trig = 1'b1; cycle(); trig = 1'b0;
      check("vec_ack", int'(ack_a), int'(vt[i].ack));
      check("vec_drop", int'(drop_a), 0);
      cycle(); check("vec_t2", int'($signed(out_a)), vt[i].o0);
      check("vec_t2_base", int'($signed(out_b)), vt[i].o0 + BASE_B);
      cycle(); check("vec_t3", int'($signed(out_a)), vt[i].o1);
      cycle(); check("vec_t4", int'($signed(out_a)), vt[i].o2);
      wait_idle(600, mono);
      check("vec_monotonic", int'(mono), 1);
      check("vec_end_out", int'($signed(out_a)), 0);
    end

    // dead-time drop, then pile-up onto the remaining tail
    amplitude = 16'd1000;
    trig = 1'b1; cycle(); trig = 1'b0;
    repeat (3) cycle();
    trig = 1'b1; cycle(); trig = 1'b0;
    check("dead_drop", int'(drop_a), 1);
    check("dead_no_ack", int'(ack_a), 0);
    o5 = int'($signed(out_a));
    cycle();
    o6 = int'($signed(out_a));
    check("dead_no_step", int'(o6 <= o5), 1);
    repeat (4) cycle();
    trig = 1'b1; cycle(); trig = 1'b0;
    check("pileup_ack", int'(ack_a), 1);
    o11 = int'($signed(out_a));
    cycle();
    o12 = int'($signed(out_a));
    check("pileup_jump", int'((o12 - o11 <= 1000) && (o12 - o11 >= 1000 - o11 / 16 - 2)), 1);
    wait_idle(600, mono);

    // saturation under repeated full-scale pulses, then a negative amplitude
    amplitude = 16'd32767;
    mino = 0; maxo = 0;
    for (int k = 0; k < 8; k++) begin
      trig = 1'b1; cycle(); trig = 1'b0;
      check("sat_ack", int'(ack_a), 1);
      for (int j = 0; j < 8; j++) begin
        cycle();
        if (int'($signed(out_a)) < mino) mino = int'($signed(out_a));
        if (int'($signed(out_a)) > maxo) maxo = int'($signed(out_a));
      end
    end
    check("sat_max", maxo, 32767);
    check("sat_nonneg", int'(mino >= 0), 1);
    amplitude = 16'(-500);
    trig = 1'b1; cycle(); trig = 1'b0;
    check("neg_ack", int'(ack_a), 1);
    prev = int'($signed(out_a));
    cycle(); cycle();
    check("neg_no_step", int'(int'($signed(out_a)) <= prev), 1);
    wait_idle(600, mono);

    // auto trigger, period 100
    amplitude = 16'd200;
    trig = 1'b1; cycle(); trig = 1'b0;
    wait_idle(600, mono);
    period = 16'd100; auto_en = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 320; i++) begin
      cycle();
      if (ack_a) acks.push_back(cyc);
    end
    check("auto100_count", acks.size(), 3);
    if (acks.size() == 3) begin
      check("auto100_first", acks[0] - t0, 100);
      check("auto100_gap1", acks[1] - acks[0], 100);
      check("auto100_gap2", acks[2] - acks[1], 100);
    end
    auto_en = 1'b0;
    wait_idle(600, mono);

    // auto trigger, period 0 behaves as 2 with drops during dead time
    acks.delete();
    n_drop = 0;
    period = 16'd0; auto_en = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (ack_a) acks.push_back(cyc);
      if (drop_a) n_drop++;
    end
    check("auto0_count", acks.size(), 5);
    check("auto0_drops", n_drop, 17);
    if (acks.size() == 5) begin
      check("auto0_first", acks[0] - t0, 2);
      for (int i = 1; i < 5; i++) check("auto0_gap", acks[i] - acks[i-1], 10);
    end
    auto_en = 1'b0;
    wait_idle(600, mono);

    // reset in the middle of a tail
    amplitude = 16'd1000;
    trig = 1'b1; cycle(); trig = 1'b0;
    for (int i = 0; i < 200 && int'($signed(out_a)) > 500; i++) cycle();
    check("midtail_reached", int'(int'($signed(out_a)) <= 500 && busy_a), 1);
    reset = 1'b1; cycle();
    check("midreset_out", int'($signed(out_a)), 0);
    check("midreset_out_base", int'($signed(out_b)), BASE_B);
    check("midreset_busy", int'(busy_a), 0);
    reset = 1'b0; cycle();
    check("postreset_out", int'($signed(out_a)), 0);
    check("postreset_busy", int'(busy_a), 0);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
